// File: rtl/mul_issue_ctrl_pkg.sv
// Shared constants and types for the HI/LO multiply issue controller.
package mul_pkg;

  localparam int MUL_LAT_DEF = 4;   // multiplier latency in rising edges
  localparam int DATA_W      = 32;  // operand / HI / LO width
  localparam int PROD_W      = 64;  // full product width

  typedef enum logic {
    IDLE = 1'b0,
    WAIT = 1'b1
  } state_t;

  // Pick the multiplier output that matches the operation's signedness.
  function automatic logic [PROD_W-1:0] select_product(
    input logic              sign,
    input logic [PROD_W-1:0] unsigned_res,
    input logic [PROD_W-1:0] signed_res
  );
    return sign ? signed_res : unsigned_res;
  endfunction

endpackage

// File: rtl/mul_issue_ctrl_if.sv
// Request, multiplier and HI/LO bundle between the pipeline and the controller.
//
// Handshake: a request transfers on a rising edge where op_valid and op_ready
// are both high. op_ready depends only on controller state, never on op_valid.
// op_valid seen while op_ready is low is ignored; nothing is queued, so the
// requester must keep op_valid (and its operands) asserted until it sees the
// transfer.
interface mul_issue_ctrl_if;
  import mul_pkg::*;

  logic              op_valid;
  logic              op_ready;
  logic              op_sign;
  logic [DATA_W-1:0] op_a;
  logic [DATA_W-1:0] op_b;
  logic              mthi_we;
  logic              mtlo_we;
  logic [DATA_W-1:0] mt_data;
  logic [DATA_W-1:0] mul_a;
  logic [DATA_W-1:0] mul_b;
  logic              mul_sign;
  logic [PROD_W-1:0] mul_unsigned_result;
  logic [PROD_W-1:0] mul_signed_result;
  logic [DATA_W-1:0] hi;
  logic [DATA_W-1:0] lo;
  logic              busy;
  logic              done;

  // Requester plus external multiplier side.
  modport master (
    output op_valid, op_sign, op_a, op_b, mthi_we, mtlo_we, mt_data,
    output mul_unsigned_result, mul_signed_result,
    input  op_ready, mul_a, mul_b, mul_sign, hi, lo, busy, done
  );

  // Controller side.
  modport slave (
    input  op_valid, op_sign, op_a, op_b, mthi_we, mtlo_we, mt_data,
    input  mul_unsigned_result, mul_signed_result,
    output op_ready, mul_a, mul_b, mul_sign, hi, lo, busy, done
  );

endinterface

// File: rtl/mul_issue_ctrl_lat_counter.sv
// Down-counter timing the multiplier latency: load, decrement, zero flag.
module lat_counter #(
  parameter int W = 3
) (
  input  logic         i_clk,
  input  logic         i_rst_n,
  input  logic         i_load,
  input  logic [W-1:0] i_load_val,
  input  logic         i_dec,
  output logic         o_zero
);

  logic [W-1:0] r_count;

  // Load has priority; decrement saturates at zero.
  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      r_count <= '0;
    end else if (i_load) begin
      r_count <= i_load_val;
    end else if (i_dec && (r_count != '0)) begin
      r_count <= r_count - 1'b1;
    end
  end

  assign o_zero = (r_count == '0);

endmodule

// File: rtl/mul_issue_ctrl.sv
// Issues one multiply at a time to an external fixed-latency multiplier,
// holds its operands stable while it works, and captures the 64-bit result
// into the architectural HI/LO registers.
module mul_issue_ctrl
  import mul_pkg::*;
#(
  parameter int MUL_LAT = MUL_LAT_DEF
) (
  input  logic            clk,
  input  logic            rst,
  mul_issue_ctrl_if.slave bus,
  output state_t          o_dbg_state
);

  localparam int              CNT_W    = (MUL_LAT < 1) ? 1 : $clog2(MUL_LAT + 1);
  localparam logic [CNT_W-1:0] LAT_LOAD = CNT_W'(MUL_LAT);

  state_t            r_state;
  state_t            w_state_nxt;
  logic              w_op_ready;
  logic              w_busy;
  logic              w_accept;
  logic              w_capture;
  logic              w_dec;
  logic              w_mt_ok;
  logic              w_cnt_zero;
  logic [PROD_W-1:0] w_product;

  logic [DATA_W-1:0] r_mul_a;
  logic [DATA_W-1:0] r_mul_b;
  logic              r_mul_sign;
  logic [DATA_W-1:0] r_hi;
  logic [DATA_W-1:0] r_lo;
  logic              r_done;

  lat_counter #(
    .W (CNT_W)
  ) u_lat_counter (
    .i_clk      (clk),
    .i_rst_n    (rst),
    .i_load     (w_accept),
    .i_load_val (LAT_LOAD),
    .i_dec      (w_dec),
    .o_zero     (w_cnt_zero)
  );

  // State register.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      r_state <= IDLE;
    end else begin
      r_state <= w_state_nxt;
    end
  end

  // Next state: leave IDLE on a request, leave WAIT once the count hits zero.
  always_comb begin
    w_state_nxt = r_state;
    case (r_state)
      IDLE:    if (bus.op_valid) w_state_nxt = WAIT;
      WAIT:    if (w_cnt_zero)   w_state_nxt = IDLE;
      default: w_state_nxt = IDLE;
    endcase
  end

  // State-decoded controls; all depend on state and counter only, except accept.
  always_comb begin
    w_op_ready = 1'b0;
    w_busy     = 1'b0;
    w_mt_ok    = 1'b0;
    w_accept   = 1'b0;
    w_capture  = 1'b0;
    w_dec      = 1'b0;
    case (r_state)
      IDLE: begin
        w_op_ready = 1'b1;
        w_mt_ok    = 1'b1;
        w_accept   = bus.op_valid;
      end
      WAIT: begin
        w_busy    = 1'b1;
        w_capture = w_cnt_zero;
        w_dec     = !w_cnt_zero;
      end
      default: ;
    endcase
  end

  assign w_product = select_product(r_mul_sign, bus.mul_unsigned_result,
                                    bus.mul_signed_result);

  // Operand registers change only on accept, so the multiplier's live
  // sign-correction inputs stay frozen for all of WAIT.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      r_mul_a    <= '0;
      r_mul_b    <= '0;
      r_mul_sign <= 1'b0;
    end else if (w_accept) begin
      r_mul_a    <= bus.op_a;
      r_mul_b    <= bus.op_b;
      r_mul_sign <= bus.op_sign;
    end
  end

  // HI/LO: product capture in WAIT, direct writes only in IDLE. The two
  // sources can never coincide, so no priority question arises.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      r_hi <= '0;
      r_lo <= '0;
    end else if (w_capture) begin
      r_hi <= w_product[PROD_W-1:DATA_W];
      r_lo <= w_product[DATA_W-1:0];
    end else if (w_mt_ok) begin
      if (bus.mthi_we) r_hi <= bus.mt_data;
      if (bus.mtlo_we) r_lo <= bus.mt_data;
    end
  end

  // Done pulses for the single cycle following the capture edge.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      r_done <= 1'b0;
    end else begin
      r_done <= w_capture;
    end
  end

  assign bus.op_ready = w_op_ready;
  assign bus.busy     = w_busy;
  assign bus.mul_a    = r_mul_a;
  assign bus.mul_b    = r_mul_b;
  assign bus.mul_sign = r_mul_sign;
  assign bus.hi       = r_hi;
  assign bus.lo       = r_lo;
  assign bus.done     = r_done;
  assign o_dbg_state  = r_state;

endmodule

// File: tb/tb_mul_issue_ctrl.sv
// Bench for mul_issue_ctrl: a latency-aware multiplier model feeds the DUT,
// and an arithmetic reference predicts HI/LO at every cycle.
module tb_mul_issue_ctrl;
  import mul_pkg::*;

  localparam int LAT = MUL_LAT_DEF;

  // ---------------- clock / reset ----------------
  logic clk = 1'b0;
  logic rst;
  always #5 clk = ~clk;

  mul_issue_ctrl_if bus ();
  state_t dbg_state;

  mul_issue_ctrl #(
    .MUL_LAT (LAT)
  ) dut (
    .clk         (clk),
    .rst         (rst),
    .bus         (bus),
    .o_dbg_state (dbg_state)
  );

  // ---------------- external multiplier model ----------------
  // Outputs a correct product only after its inputs have been stable for LAT
  // rising edges; before that it drives an obvious junk value.
  logic [64:0] mm_last = '0;
  int          mm_cnt  = 0;
  wire  [64:0] mm_cur  = {bus.mul_sign, bus.mul_a, bus.mul_b};
  always @(posedge clk) begin
    if (mm_cur !== mm_last) begin
      mm_last <= mm_cur;
      mm_cnt  <= 1;
    end else if (mm_cnt < 1000) begin
      mm_cnt <= mm_cnt + 1;
    end
  end
  wire mm_ok = (mm_cnt >= LAT) && (mm_cur === mm_last);
  assign bus.mul_unsigned_result = mm_ok ? ({32'd0, bus.mul_a} * {32'd0, bus.mul_b})
                                         : 64'hBAD0_BAD0_BAD0_BAD0;
  assign bus.mul_signed_result   = mm_ok ? ({{32{bus.mul_a[31]}}, bus.mul_a} *
                                            {{32{bus.mul_b[31]}}, bus.mul_b})
                                         : 64'h5A5A_5A5A_5A5A_5A5A;

  // ---------------- reference model / scoreboard ----------------
  int          total = 0;
  int          bad   = 0;
  logic [31:0] m_hi  = '0;
  logic [31:0] m_lo  = '0;
  logic [63:0] exp_q[$];

  function automatic logic [63:0] ref_product(input logic [31:0] a, input logic [31:0] b,
                                              input logic s);
    longint          sa, sb;
    longint unsigned ua, ub;
    if (s) begin
      sa = $signed(a);
      sb = $signed(b);
      return sa * sb;
    end
    ua = a;
    ub = b;
    return ua * ub;
  endfunction

  function automatic logic [31:0] pick_operand();
    case ($urandom_range(0, 4))
      0:       return 32'h0000_0000;
      1:       return 32'hFFFF_FFFF;
      2:       return 32'h8000_0000;
      3:       return 32'h7FFF_FFFF;
      default: return $urandom;
    endcase
  endfunction

  // ---------------- driver tasks ----------------
  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic drive_idle();
    bus.op_valid = 1'b0;
    bus.op_sign  = 1'b0;
    bus.op_a     = '0;
    bus.op_b     = '0;
    bus.mthi_we  = 1'b0;
    bus.mtlo_we  = 1'b0;
    bus.mt_data  = '0;
  endtask

  // One full operation. mode 0: quiet WAIT; 1: random ignored traffic during
  // WAIT; 2: mtlo_we with 0xDEADBEEF held throughout WAIT.
  task automatic run_op(input logic [31:0] a, input logic [31:0] b, input logic s,
                        input int mode, input logic mh, input logic ml,
                        input logic [31:0] md, input string tag);
    logic [63:0] e;
    bus.op_valid = 1'b1;
    bus.op_a     = a;
    bus.op_b     = b;
    bus.op_sign  = s;
    bus.mthi_we  = mh;
    bus.mtlo_we  = ml;
    bus.mt_data  = md;
    total++;
    if (bus.op_ready !== 1'b1)
      $display("FAIL %s accept_ready: got %b exp 1", tag, bus.op_ready);
    exp_q.push_back(ref_product(a, b, s));
    tick();
    if (mh) m_hi = md;
    if (ml) m_lo = md;
    drive_idle();
    for (int k = 0; k <= LAT; k++) begin
      total++;
      if (bus.busy !== 1'b1 || bus.op_ready !== 1'b0 || bus.done !== 1'b0) begin
        bad++;
        $display("FAIL %s wait_flags c%0d: busy=%b ready=%b done=%b exp 1/0/0",
                 tag, k, bus.busy, bus.op_ready, bus.done);
      end
      total++;
      if (bus.mul_a !== a || bus.mul_b !== b || bus.mul_sign !== s) begin
        bad++;
        $display("FAIL %s operand_hold c%0d: got %h/%h/%b exp %h/%h/%b",
                 tag, k, bus.mul_a, bus.mul_b, bus.mul_sign, a, b, s);
      end
      total++;
      if (bus.hi !== m_hi || bus.lo !== m_lo) begin
        bad++;
        $display("FAIL %s hilo_hold c%0d: got %h_%h exp %h_%h",
                 tag, k, bus.hi, bus.lo, m_hi, m_lo);
      end
      if (mode == 1) begin
        bus.op_valid = 1'($urandom_range(0, 1));
        bus.op_a     = $urandom;
        bus.op_b     = $urandom;
        bus.op_sign  = 1'($urandom_range(0, 1));
        bus.mthi_we  = 1'($urandom_range(0, 1));
        bus.mtlo_we  = 1'($urandom_range(0, 1));
        bus.mt_data  = $urandom;
      end else if (mode == 2) begin
        bus.mtlo_we = 1'b1;
        bus.mt_data = 32'hDEAD_BEEF;
      end
      tick();
    end
    drive_idle();
    e = (exp_q.size() != 0) ? exp_q.pop_front() : 64'hx;
    m_hi = e[63:32];
    m_lo = e[31:0];
    total++;
    if (bus.hi !== m_hi || bus.lo !== m_lo) begin
      bad++;
      $display("FAIL %s capture: got %h_%h exp %h_%h", tag, bus.hi, bus.lo, m_hi, m_lo);
    end
    total++;
    if (bus.done !== 1'b1 || bus.op_ready !== 1'b1 || bus.busy !== 1'b0) begin
      bad++;
      $display("FAIL %s post_capture: done=%b ready=%b busy=%b exp 1/1/0",
               tag, bus.done, bus.op_ready, bus.busy);
    end
    tick();
    total++;
    if (bus.done !== 1'b0 || bus.hi !== m_hi || bus.lo !== m_lo) begin
      bad++;
      $display("FAIL %s done_single: done=%b hilo=%h_%h exp 0 %h_%h",
               tag, bus.done, bus.hi, bus.lo, m_hi, m_lo);
    end
  endtask

  // ---------------- tests ----------------
  task automatic test_reset();
    drive_idle();
    rst = 1'b1;
    #2 rst = 1'b0;
    #1;
    total++;
    if (bus.hi !== 32'h0 || bus.lo !== 32'h0 || bus.mul_a !== 32'h0 ||
        bus.mul_b !== 32'h0 || bus.mul_sign !== 1'b0) begin
      bad++;
      $display("FAIL reset_regs: hi=%h lo=%h a=%h b=%h s=%b exp all 0",
               bus.hi, bus.lo, bus.mul_a, bus.mul_b, bus.mul_sign);
    end
    total++;
    if (bus.op_ready !== 1'b1 || bus.busy !== 1'b0 || bus.done !== 1'b0 || dbg_state !== IDLE) begin
      bad++;
      $display("FAIL reset_flags: ready=%b busy=%b done=%b state=%0d exp 1/0/0/IDLE",
               bus.op_ready, bus.busy, bus.done, dbg_state);
    end
    tick();
    tick();
    rst = 1'b1;
  endtask

  task automatic test_unsigned();
    run_op(32'hFFFF_FFFF, 32'h0000_0002, 1'b0, 0, 1'b0, 1'b0, 32'h0, "unsigned");
    run_op(32'h0001_0000, 32'h0001_0000, 1'b0, 1, 1'b0, 1'b0, 32'h0, "unsigned_2");
  endtask

  task automatic test_signed();
    run_op(32'hFFFF_FFFD, 32'h0000_0005, 1'b1, 0, 1'b0, 1'b0, 32'h0, "signed_m3x5");
    run_op(32'hFFFF_FFFF, 32'hFFFF_FFFF, 1'b1, 0, 1'b0, 1'b0, 32'h0, "signed_m1xm1");
    run_op(32'hFFFF_FFFF, 32'hFFFF_FFFF, 1'b0, 0, 1'b0, 1'b0, 32'h0, "unsigned_ffxff");
  endtask

  task automatic test_direct_write();
    bus.mthi_we = 1'b1;
    bus.mt_data = 32'h1234_5678;
    tick();
    m_hi = 32'h1234_5678;
    drive_idle();
    total++;
    if (bus.hi !== m_hi || bus.lo !== m_lo) begin
      bad++;
      $display("FAIL mthi: got %h_%h exp %h_%h", bus.hi, bus.lo, m_hi, m_lo);
    end
    bus.mthi_we = 1'b1;
    bus.mtlo_we = 1'b1;
    bus.mt_data = 32'hC0FF_EE00;
    tick();
    m_hi = 32'hC0FF_EE00;
    m_lo = 32'hC0FF_EE00;
    drive_idle();
    total++;
    if (bus.hi !== m_hi || bus.lo !== m_lo) begin
      bad++;
      $display("FAIL mt_both: got %h_%h exp %h_%h", bus.hi, bus.lo, m_hi, m_lo);
    end
    run_op($urandom, $urandom, 1'b0, 2, 1'b0, 1'b0, 32'h0, "mtlo_in_wait");
  endtask

  task automatic test_back_to_back();
    logic [31:0] a1, b1, a2, b2;
    logic        s1, s2;
    logic [63:0] e;
    int          low;
    a1 = $urandom; b1 = $urandom; s1 = 1'($urandom_range(0, 1));
    a2 = $urandom; b2 = $urandom; s2 = 1'($urandom_range(0, 1));
    bus.op_valid = 1'b1;
    bus.op_a = a1; bus.op_b = b1; bus.op_sign = s1;
    exp_q.push_back(ref_product(a1, b1, s1));
    tick();
    bus.op_a = a2; bus.op_b = b2; bus.op_sign = s2;
    low = 0;
    for (int c = 0; c < 20; c++) begin
      if (bus.op_ready === 1'b1) break;
      low++;
      total++;
      if (bus.mul_a !== a1 || bus.mul_b !== b1 || bus.mul_sign !== s1) begin
        bad++;
        $display("FAIL b2b_hold1: got %h/%h exp %h/%h", bus.mul_a, bus.mul_b, a1, b1);
      end
      tick();
    end
    total++;
    if (low != LAT + 1) begin
      bad++;
      $display("FAIL b2b_ready_low: got %0d cycles exp %0d", low, LAT + 1);
    end
    e = (exp_q.size() != 0) ? exp_q.pop_front() : 64'hx;
    m_hi = e[63:32];
    m_lo = e[31:0];
    total++;
    if (bus.hi !== m_hi || bus.lo !== m_lo || bus.done !== 1'b1) begin
      bad++;
      $display("FAIL b2b_capture1: got %h_%h done=%b exp %h_%h 1",
               bus.hi, bus.lo, bus.done, m_hi, m_lo);
    end
    exp_q.push_back(ref_product(a2, b2, s2));
    tick();
    bus.op_valid = 1'b0;
    total++;
    if (bus.busy !== 1'b1 || bus.mul_a !== a2 || bus.mul_b !== b2 || bus.mul_sign !== s2) begin
      bad++;
      $display("FAIL b2b_accept2: busy=%b a=%h b=%h exp 1 %h %h", bus.busy, bus.mul_a, bus.mul_b, a2, b2);
    end
    for (int k = 0; k <= LAT; k++) begin
      total++;
      if (bus.mul_a !== a2 || bus.mul_b !== b2 || bus.hi !== m_hi || bus.lo !== m_lo) begin
        bad++;
        $display("FAIL b2b_hold2 c%0d: a=%h b=%h hilo=%h_%h", k, bus.mul_a, bus.mul_b, bus.hi, bus.lo);
      end
      tick();
    end
    e = (exp_q.size() != 0) ? exp_q.pop_front() : 64'hx;
    m_hi = e[63:32];
    m_lo = e[31:0];
    total++;
    if (bus.hi !== m_hi || bus.lo !== m_lo || bus.done !== 1'b1) begin
      bad++;
      $display("FAIL b2b_capture2: got %h_%h done=%b exp %h_%h 1",
               bus.hi, bus.lo, bus.done, m_hi, m_lo);
    end
    drive_idle();
    tick();
  endtask

  task automatic test_reset_mid();
    bus.op_valid = 1'b1;
    bus.op_a = 32'h0000_1234; bus.op_b = 32'h0000_5678; bus.op_sign = 1'b0;
    tick();
    drive_idle();
    tick();
    tick();
    rst = 1'b0;
    #1;
    exp_q.delete();
    m_hi = '0;
    m_lo = '0;
    total++;
    if (bus.hi !== 32'h0 || bus.lo !== 32'h0 || bus.op_ready !== 1'b1 ||
        bus.busy !== 1'b0 || bus.mul_a !== 32'h0 || dbg_state !== IDLE) begin
      bad++;
      $display("FAIL reset_mid: hi=%h lo=%h ready=%b busy=%b a=%h exp 0 0 1 0 0",
               bus.hi, bus.lo, bus.op_ready, bus.busy, bus.mul_a);
    end
    tick();
    rst = 1'b1;
    for (int k = 0; k < LAT + 4; k++) begin
      tick();
      total++;
      if (bus.done !== 1'b0 || bus.hi !== 32'h0 || bus.lo !== 32'h0 || bus.op_ready !== 1'b1) begin
        bad++;
        $display("FAIL reset_mid_after c%0d: done=%b hilo=%h_%h ready=%b exp 0 0_0 1",
                 k, bus.done, bus.hi, bus.lo, bus.op_ready);
      end
    end
    // Accept on the very first edge after a release.
    rst = 1'b0;
    tick();
    rst = 1'b1;
    run_op(32'h8000_0000, 32'h0000_0002, 1'b1, 0, 1'b0, 1'b0, 32'h0, "first_after_rst");
  endtask

  task automatic test_simultaneous();
    run_op(32'h0000_0003, 32'h0000_0007, 1'b0, 0, 1'b1, 1'b0, 32'hAAAA_AAAA, "accept_mthi");
    run_op(32'h8000_0001, 32'h0000_0003, 1'b1, 0, 1'b1, 1'b1, 32'h5555_5555, "accept_mt_both");
  endtask

  task automatic test_random();
    for (int n = 0; n < 24; n++) begin
      if ($urandom_range(0, 2) == 0) begin
        bus.mthi_we = 1'($urandom_range(0, 1));
        bus.mtlo_we = 1'($urandom_range(0, 1));
        bus.mt_data = $urandom;
        tick();
        if (bus.mthi_we) m_hi = bus.mt_data;
        if (bus.mtlo_we) m_lo = bus.mt_data;
        drive_idle();
        total++;
        if (bus.hi !== m_hi || bus.lo !== m_lo) begin
          bad++;
          $display("FAIL rand_mt n%0d: got %h_%h exp %h_%h", n, bus.hi, bus.lo, m_hi, m_lo);
        end
      end
      run_op(pick_operand(), pick_operand(), 1'($urandom_range(0, 1)),
             int'($urandom_range(0, 1)), 1'($urandom_range(0, 1)),
             1'($urandom_range(0, 1)), $urandom, "random");
    end
  endtask

  // ---------------- sequence / report ----------------
  initial begin
    test_reset();
    test_unsigned();
    test_signed();
    test_direct_write();
    test_back_to_back();
    test_simultaneous();
    test_reset_mid();
    test_random();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
